// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter between instruction fetch and load/store unit
//
// Purpose:
//   Grants the single memory port to IF or LSU, one outstanding transaction
//   at a time. The transaction is sequenced with a req/ready/rvalid handshake,
//   and the response is routed back to the requester that owns it.
//   LSU wins ties because it carries the older instruction.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   When defined, a counter tracks consecutive LSU grants made while IF waits.
//   After STARVE_LIMIT such grants, IF receives the next grant.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_valid)
//   if_rdata/if_valid             fetch response, one-cycle pulse
//   lsu_req/we/addr/wdata/wmask   data request (held until lsu_valid)
//   lsu_rdata/lsu_valid           data response, one-cycle pulse (loads and stores)
//   mem_req/we/addr/wdata/wmask   memory request, driven from latched fields only
//   mem_ready                     memory accepts the request this cycle
//   mem_rvalid/mem_rdata          memory response
//   stall_if/stall_lsu            pipeline stall requests

module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_lsu
);

  localparam int MASK_W = DATA_W / 8;

  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner_lsu;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;

  logic                w_grant_lsu;
  logic                w_grant_if;
  logic                w_complete;
  logic                w_force_if;
  logic                w_done;

  // Next-state and grant decision
  always_comb begin
    w_state_nxt = r_state;
    w_grant_lsu = 1'b0;
    w_grant_if  = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lsu_req && !w_force_if) begin
          w_grant_lsu = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (if_req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // rvalid without ready here is a stale response and is ignored
        if (mem_ready) begin
          if (mem_rvalid) begin
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and latched request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_lsu <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_lsu) begin
        r_owner_lsu <= 1'b1;
        r_we        <= lsu_we;
        r_addr      <= lsu_addr;
        r_wdata     <= lsu_wdata;
        r_wmask     <= lsu_wmask;
      end else if (w_grant_if) begin
        r_owner_lsu <= 1'b0;
        r_we        <= 1'b0;
        r_addr      <= if_addr;
        r_wdata     <= '0;
        r_wmask     <= '0;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;

  // Only force IF when it is actually waiting; otherwise LSU keeps priority
  assign w_force_if = if_req && (r_starve_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_if) begin
      r_starve_cnt <= '0;
    end else if ((r_state == S_IDLE) && !if_req) begin
      r_starve_cnt <= '0;
    end else if (w_grant_lsu && if_req && (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // Outputs are masked during rst so a transaction cut off by reset
  // never leaks a request or a completion pulse.
  assign w_done    = w_complete & ~rst;
  assign mem_req   = (r_state == S_ISSUE) & ~rst;
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? r_addr  : '0;
  assign mem_wdata = mem_req ? r_wdata : '0;
  assign mem_wmask = mem_req ? r_wmask : '0;

  assign if_valid  = w_done & ~r_owner_lsu;
  assign lsu_valid = w_done &  r_owner_lsu;
  assign if_rdata  = if_valid  ? mem_rdata : '0;
  assign lsu_rdata = lsu_valid ? mem_rdata : '0;

  assign stall_if  = if_req  & ~if_valid  & ~rst;
  assign stall_lsu = lsu_req & ~lsu_valid & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic [63:0] if_rdata;
  logic        if_valid;
  logic        lsu_req;
  logic        lsu_we;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic [63:0] lsu_rdata;
  logic        lsu_valid;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        stall_if;
  logic        stall_lsu;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_rdata(lsu_rdata), .lsu_valid(lsu_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_lsu(stall_lsu)
  );

  typedef struct {
    logic        rst, ir;
    logic [63:0] ia;
    logic        lr, lw;
    logic [63:0] la, ld;
    logic [7:0]  lm;
    logic        rdy, rv;
    logic [63:0] rd;
    logic        eq, ew;
    logic [63:0] ea, ed;
    logic [7:0]  em;
    logic        eiv;
    logic [63:0] eid;
    logic        elv;
    logic [63:0] eld;
    logic        esi, esl;
  } vec_t;

  function automatic vec_t mk(
    input logic r, ir, input logic [63:0] ia, input logic lr, lw,
    input logic [63:0] la, ld, input logic [7:0] lm, input logic rdy, rv,
    input logic [63:0] rd, input logic eq, ew, input logic [63:0] ea, ed,
    input logic [7:0] em, input logic eiv, input logic [63:0] eid,
    input logic elv, input logic [63:0] eld, input logic esi, esl);
    vec_t v;
    v.rst = r;  v.ir = ir; v.ia = ia; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
    v.lm = lm;  v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.eq = eq;  v.ew = ew; v.ea = ea; v.ed = ed; v.em = em;
    v.eiv = eiv; v.eid = eid; v.elv = elv; v.eld = eld; v.esi = esi; v.esl = esl;
    return v;
  endfunction

  vec_t tv[$];

  task automatic drive_idle();
    rst = 1'b0; if_req = 1'b0; if_addr = '0; lsu_req = 1'b0; lsu_we = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    logic exp_lsu[6];
    int   g;
    int   cyc;
    logic bad;

    drive_idle();
    rst = 1'b1;

    //      r ir ia            lr lw la       ld     lm     rdy rv rd        | eq ew ea           ed     em     eiv eid     elv eld      esi esl
    tv.push_back(mk(1,0,0,          0,0,0,       0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       0,0)); // reset
    tv.push_back(mk(1,0,0,          0,0,0,       0,     0,     0,1,'hDEAD,   0,0,0,          0,     0,     0,0,      0,0,       0,0)); // stale rvalid in reset
    tv.push_back(mk(0,1,'h80000000, 0,0,0,       0,     0,     1,1,'h13,     0,0,0,          0,     0,     0,0,      0,0,       1,0)); // IF seen in IDLE
    tv.push_back(mk(0,1,'h80000000, 0,0,0,       0,     0,     1,1,'h13,     1,0,'h80000000, 0,     0,     1,'h13,   0,0,       0,0)); // zero-wait fetch
    tv.push_back(mk(0,0,0,          0,0,0,       0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       0,0));
    tv.push_back(mk(0,1,'h2000,     1,1,'h1000,  'hAA,  'hFF,  0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       1,1)); // tie
    tv.push_back(mk(0,1,'h2000,     1,1,'h1000,  'hAA,  'hFF,  1,1,'h55,     1,1,'h1000,     'hAA,  'hFF,  0,0,      1,'h55,    1,0)); // LSU store first
    tv.push_back(mk(0,1,'h2000,     0,0,0,       0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       1,0));
    tv.push_back(mk(0,1,'h2000,     0,0,0,       0,     0,     1,1,'h77,     1,0,'h2000,     0,     0,     1,'h77,   0,0,       0,0)); // then IF
    tv.push_back(mk(0,0,0,          0,0,0,       0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       0,0));
    tv.push_back(mk(0,0,0,          1,0,'h3000,  0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       0,1)); // load granted
    tv.push_back(mk(0,0,0,          1,1,'h4444,  'h99,  'h0F,  0,0,0,        1,0,'h3000,     0,     0,     0,0,      0,0,       0,1)); // inputs change, no effect
    tv.push_back(mk(0,0,0,          1,1,'h4444,  'h99,  'h0F,  0,1,'hBAD,    1,0,'h3000,     0,     0,     0,0,      0,0,       0,1)); // rvalid w/o ready ignored
    tv.push_back(mk(0,0,0,          1,1,'h4444,  'h99,  'h0F,  0,0,0,        1,0,'h3000,     0,     0,     0,0,      0,0,       0,1));
    tv.push_back(mk(0,0,0,          1,1,'h4444,  'h99,  'h0F,  1,0,0,        1,0,'h3000,     0,     0,     0,0,      0,0,       0,1)); // accepted -> WAIT
    tv.push_back(mk(0,0,0,          1,0,'h3000,  0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       0,1));
    tv.push_back(mk(0,0,0,          1,0,'h3000,  0,     0,     0,1,'h1234,   0,0,0,          0,     0,     0,0,      1,'h1234,  0,0)); // response
    tv.push_back(mk(0,0,0,          0,0,0,       0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       0,0)); // no second req
    tv.push_back(mk(0,0,0,          1,0,'h5000,  0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       0,1));
    tv.push_back(mk(0,0,0,          1,0,'h5000,  0,     0,     1,0,0,        1,0,'h5000,     0,     0,     0,0,      0,0,       0,1));
    tv.push_back(mk(1,0,0,          1,0,'h5000,  0,     0,     0,1,'hEE,     0,0,0,          0,     0,     0,0,      0,0,       0,0)); // rst in WAIT
    tv.push_back(mk(0,0,0,          0,0,0,       0,     0,     0,1,'hEE,     0,0,0,          0,     0,     0,0,      0,0,       0,0)); // late rvalid ignored
    tv.push_back(mk(0,1,'h6000,     0,0,0,       0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       1,0));
    tv.push_back(mk(0,1,'h6000,     0,0,0,       0,     0,     1,1,'h66,     1,0,'h6000,     0,     0,     1,'h66,   0,0,       0,0)); // fresh fetch ok
    tv.push_back(mk(0,0,0,          0,0,0,       0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       0,0));
    tv.push_back(mk(0,1,'h7000,     0,0,0,       0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       1,0));
    tv.push_back(mk(0,0,0,          0,0,0,       0,     0,     1,0,0,        1,0,'h7000,     0,     0,     0,0,      0,0,       0,0)); // IF drops req
    tv.push_back(mk(0,0,0,          0,0,0,       0,     0,     0,1,'h70,     0,0,0,          0,     0,     1,'h70,   0,0,       0,0)); // still pulses
    tv.push_back(mk(0,0,0,          0,0,0,       0,     0,     0,0,0,        0,0,0,          0,     0,     0,0,      0,0,       0,0));

    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst; if_req = tv[i].ir; if_addr = tv[i].ia;
      lsu_req = tv[i].lr; lsu_we = tv[i].lw; lsu_addr = tv[i].la;
      lsu_wdata = tv[i].ld; lsu_wmask = tv[i].lm;
      mem_ready = tv[i].rdy; mem_rvalid = tv[i].rv; mem_rdata = tv[i].rd;
      #1;
      n_vec++;
      bad = (mem_req !== tv[i].eq) || (mem_we !== tv[i].ew) || (mem_addr !== tv[i].ea) ||
            (mem_wdata !== tv[i].ed) || (mem_wmask !== tv[i].em) ||
            (if_valid !== tv[i].eiv) || (if_rdata !== tv[i].eid) ||
            (lsu_valid !== tv[i].elv) || (lsu_rdata !== tv[i].eld) ||
            (stall_if !== tv[i].esi) || (stall_lsu !== tv[i].esl);
      if (bad) begin
        n_fail++;
        $display("FAIL vec%0d: got req=%b we=%b addr=%h wd=%h m=%h ifv=%b ifd=%h lv=%b ld=%h sif=%b sl=%b; want req=%b we=%b addr=%h wd=%h m=%h ifv=%b ifd=%h lv=%b ld=%h sif=%b sl=%b",
                 i, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, if_valid, if_rdata,
                 lsu_valid, lsu_rdata, stall_if, stall_lsu,
                 tv[i].eq, tv[i].ew, tv[i].ea, tv[i].ed, tv[i].em, tv[i].eiv, tv[i].eid,
                 tv[i].elv, tv[i].eld, tv[i].esi, tv[i].esl);
      end
    end

    // Starvation sequence: both requesters held high, zero-wait memory.
`ifdef ARB_STARVE_GUARD_EN
    exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b1; if_addr = 64'h2000;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h1000; lsu_wdata = 64'hAA; lsu_wmask = 8'hFF;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h5;
    g = 0;
    cyc = 0;
    while (g < 6 && cyc < 40) begin
      #1;
      if (mem_req) begin
        n_vec++;
        if ((mem_addr == 64'h1000) !== exp_lsu[g]) begin
          n_fail++;
          $display("FAIL grant%0d: got lsu_owner=%b addr=%h; want lsu_owner=%b",
                   g, (mem_addr == 64'h1000), mem_addr, exp_lsu[g]);
        end
        g++;
      end
      @(negedge clk);
      cyc++;
    end
    if (g < 6) begin
      n_vec++;
      n_fail++;
      $display("FAIL grant_timeout: got %0d grants; want 6", g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single shared memory port between instruction fetch (IF) and load/store unit (LSU) of the 5-stage core.
Allows one outstanding transaction at a time and sequences it with a request/ready/rvalid handshake to memory.
Routes the response back to the owning requester.
Produces stall requests that feed the pipeline hazard controller alongside its load-use stalls.

Parameters:
ADDR_W, 64, address width of all address ports
DATA_W, 64, data width of read/write data
STARVE_LIMIT, 4, consecutive LSU grants while IF waits before IF is forced (only used with ARB_STARVE_GUARD_EN)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
if_req  input  1  fetch request; held until if_valid
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetch data, valid with if_valid
if_valid  output  1  one-cycle fetch completion
lsu_req  input  1  data request; held until lsu_valid
lsu_we  input  1  1=store, 0=load
lsu_addr  input  ADDR_W  data address
lsu_wdata  input  DATA_W  store data
lsu_wmask  input  DATA_W/8  store byte mask
lsu_rdata  output  DATA_W  load data, valid with lsu_valid
lsu_valid  output  1  one-cycle data completion (loads and stores)
mem_req  output  1  request to memory
mem_we  output  1  write enable
mem_addr  output  ADDR_W  address
mem_wdata  output  DATA_W  write data
mem_wmask  output  DATA_W/8  write byte mask
mem_ready  input  1  memory accepts request this cycle
mem_rvalid  input  1  memory response (read data or write ack)
mem_rdata  input  DATA_W  memory read data
stall_if  output  1  if_req & ~if_valid
stall_lsu  output  1  lsu_req & ~lsu_valid

Behaviour:
- Clock and reset: clk; synchronous, active-high rst.
- FSM states: IDLE, ISSUE, WAIT. Owner register: IF or LSU.
- IDLE: if lsu_req, grant LSU; else if if_req, grant IF. LSU wins ties because it is the older instruction.
  - On grant, latch we/addr/wdata/wmask (IF: we=0, mask=0) and owner, then go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mem_req=1 with the latched fields.
  - mem_ready=0: stay in ISSUE.
  - mem_ready=1 and mem_rvalid=0: go to WAIT.
  - mem_ready=1 and mem_rvalid=1 (zero-wait memory): complete this cycle and go to IDLE.
- WAIT: mem_req=0. On mem_rvalid, complete and go to IDLE.
- Complete: assert the owner's valid for exactly one cycle, with rdata = mem_rdata (combinational pass-through). The other valid stays 0.
- mem_* outputs are driven only from latched registers, never combinationally from requester inputs. mem_addr/we/wdata/wmask are 0 when mem_req=0.
- Minimum latency, request seen in IDLE at cycle 0: mem_req at cycle 1; valid at cycle 1 with zero-wait memory. Next grant is evaluated in IDLE at cycle 2.
- Requester inputs changing after grant have no effect. A requester dropping req mid-transaction does not abort it; its valid still pulses.
- mem_rvalid in IDLE or ISSUE without mem_ready is ignored. This covers stale responses after reset.
- Reset values:
  - state=IDLE, owner=IF, latched fields 0, starvation counter 0.
  - mem_req, mem_we, if_valid and lsu_valid are 0.
  - mem_addr, mem_wdata, mem_wmask, if_rdata and lsu_rdata are 0.
- Reset mid-transaction abandons the transaction; no valid is pulsed.
- stall_if and stall_lsu are combinational, and 0 during rst.

Optional Feature:
ARB_STARVE_GUARD_EN:
- Defined: a counter (width clog2(STARVE_LIMIT+1)) increments on each LSU grant made while if_req=1.
  - It clears on any IF grant, and on any IDLE cycle with if_req=0.
  - When the counter reaches STARVE_LIMIT, the next IDLE grant goes to IF even if lsu_req=1.
- Undefined: strict LSU priority; no counter logic.

Test Plan:
- Reset, then if_req=1, if_addr=0x80000000, zero-wait memory returning 0x00000013 -> mem_req at cycle 1 with addr 0x80000000, we=0; if_valid=1 and if_rdata=0x13 at cycle 1; stall_if=1 at cycle 0 only.
- if_req and lsu_req rise in the same cycle (lsu_we=1, addr 0x1000, wdata 0xAA, mask 0xFF) -> LSU served first with mem_we=1, mask 0xFF; IF served next; each valid pulses once.
- Memory holds mem_ready=0 for 3 cycles, then rvalid 2 cycles after ready -> mem_req and fields stable for 4 cycles; lsu_valid exactly once; no second mem_req.
- rst asserted while in WAIT, then mem_rvalid arrives -> no valid pulses; all outputs 0; a fresh if_req is granted normally.
- With ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, lsu_req and if_req held high -> LSU, LSU, LSU, LSU, IF, LSU... grant order. Without the macro -> LSU only while lsu_req=1.
